// File: rtl/tdnn_pkg.sv
// Shared state encoding, Q-format shifts and weight-memory layout helpers for the TDNN MAC engine.
package tdnn_pkg;

  typedef enum logic [2:0] {S_IDLE, S_L1, S_L2, S_L3, S_OUT} state_t;

  localparam int Q_SHIFT_L1  = 22;
  localparam int Q_SHIFT_L23 = 15;
  localparam int Q_SHIFT_OUT = 7;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Each layer stores G*fan_in weight words followed by G bias words.
  function automatic int l2_base(input int in_dim, input int h1, input int nm);
    return ceil_div(h1, nm) * (in_dim + 1);
  endfunction

  function automatic int l3_base(input int in_dim, input int h1, input int h2, input int nm);
    return l2_base(in_dim, h1, nm) + ceil_div(h2, nm) * (h1 + 1);
  endfunction

  function automatic int bank_size(input int in_dim, input int h1, input int h2,
                                   input int od, input int nm);
    return l3_base(in_dim, h1, h2, nm) + ceil_div(od, nm) * (h2 + 1);
  endfunction

endpackage

// File: rtl/tdnn_mac_lane.sv
// One MAC lane: multiply-accumulate, bias align, round-half-up to Q8.8, saturate, activation.
module tdnn_mac_lane
  import tdnn_pkg::*;
#(
  parameter int ACC_WIDTH   = 40,
  parameter int ALPHA_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        mac_en,
  input  logic        l1_mode,
  input  logic        l3_mode,
  input  logic [15:0] act,
  input  logic [15:0] wd,
  output logic [15:0] res
);
  localparam int SW = ACC_WIDTH + 1;
  localparam logic signed [SW-1:0] Q_MAX = SW'(32767);
  localparam logic signed [SW-1:0] Q_MIN = -SW'(32768);

  logic signed [31:0]          prod;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [SW-1:0]        bias_ext;
  logic signed [SW-1:0]        sum;
  logic signed [SW-1:0]        shr;
  logic signed [15:0]          q88;
  logic signed [15:0]          ht;
  logic signed [15:0]          leaky;

  assign prod = $signed(act) * $signed(wd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      acc_q <= '0;
    else if (clr)    acc_q <= '0;
    else if (mac_en) acc_q <= acc_q + {{(ACC_WIDTH-32){prod[31]}}, prod};
  end

  // The bias word arrives on the writeback cycle, so it is folded in combinationally.
  always_comb begin
    bias_ext = {{(SW-16){wd[15]}}, wd};
    if (l1_mode) begin
      sum = {acc_q[ACC_WIDTH-1], acc_q} + (bias_ext <<< Q_SHIFT_L1)
            + (SW'(1) <<< (Q_SHIFT_L1 - 1));
      shr = sum >>> Q_SHIFT_L1;
    end else begin
      sum = {acc_q[ACC_WIDTH-1], acc_q} + (bias_ext <<< Q_SHIFT_L23)
            + (SW'(1) <<< (Q_SHIFT_L23 - 1));
      shr = sum >>> Q_SHIFT_L23;
    end
    if (shr > Q_MAX)      q88 = 16'sh7FFF;
    else if (shr < Q_MIN) q88 = 16'sh8000;
    else                  q88 = shr[15:0];
    if (q88 > 16'sd255)       ht = 16'sd255;
    else if (q88 < -16'sd256) ht = -16'sd256;
    else                      ht = q88;
    leaky = q88[15] ? (q88 >>> ALPHA_SHIFT) : q88;
    res   = l3_mode ? (ht <<< Q_SHIFT_OUT) : leaky;
  end

endmodule

// File: rtl/tdnn_mac_engine.sv
// Three-layer TDNN inference engine: NUM_MACS lanes stream weights from an external banked memory.
module tdnn_mac_engine
  import tdnn_pkg::*;
#(
  parameter int IN_DIM      = 22,
  parameter int H1_DIM      = 32,
  parameter int H2_DIM      = 16,
  parameter int OUT_DIM     = 2,
  parameter int NUM_MACS    = 4,
  parameter int NUM_BANKS   = 4,
  parameter int ALPHA_SHIFT = 2,
  parameter int ACC_WIDTH   = 40,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [16*IN_DIM-1:0]         in_vector,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(NUM_BANKS)-1:0] bank_sel,
  output logic [ADDR_WIDTH-1:0]        w_addr,
  output logic                         w_rd,
  input  logic [16*NUM_MACS-1:0]       w_data,
  output logic [15:0]                  out_i,
  output logic [15:0]                  out_q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);
  localparam int AW        = ADDR_WIDTH;
  localparam int G1        = ceil_div(H1_DIM, NUM_MACS);
  localparam int G2        = ceil_div(H2_DIM, NUM_MACS);
  localparam int G3        = ceil_div(OUT_DIM, NUM_MACS);
  localparam int L2_BASE   = l2_base(IN_DIM, H1_DIM, NUM_MACS);
  localparam int L3_BASE   = l3_base(IN_DIM, H1_DIM, H2_DIM, NUM_MACS);
  localparam int BANK_SIZE = bank_size(IN_DIM, H1_DIM, H2_DIM, OUT_DIM, NUM_MACS);
  localparam int IW1       = $clog2(IN_DIM);
  localparam int IW2       = $clog2(H1_DIM);
  localparam int IW3       = $clog2(H2_DIM);
  localparam int OW        = $clog2(OUT_DIM);
  localparam logic [AW-1:0] ONE = AW'(1);

  state_t                       state_q, state_d;
  logic [AW-1:0]                k_q, grp_q, fan, ngrp, base, idx, addr;
  logic [$clog2(NUM_BANKS)-1:0] bank_q;
  logic [IN_DIM-1:0][15:0]      x_q;
  logic [H1_DIM-1:0][15:0]      h1_q;
  logic [H2_DIM-1:0][15:0]      h2_q;
  logic [OUT_DIM-1:0][15:0]     h3_q;
  logic [NUM_MACS-1:0][15:0]    res;
  logic [NUM_MACS-1:0][AW-1:0]  nidx;
  logic [15:0]                  act;
  logic accept, in_layer, mac_en, wb, fin, last_grp;

  always_comb begin
    fan  = AW'(IN_DIM);
    ngrp = AW'(G1);
    base = '0;
    if (state_q == S_L2) begin
      fan = AW'(H1_DIM); ngrp = AW'(G2); base = AW'(L2_BASE);
    end else if (state_q == S_L3) begin
      fan = AW'(H2_DIM); ngrp = AW'(G3); base = AW'(L3_BASE);
    end
  end

  // Per group: k=0..fan-1 weight reads, k=fan bias read, k=fan+1 writeback; L3 adds k=fan+2 to publish.
  assign in_layer  = (state_q == S_L1) || (state_q == S_L2) || (state_q == S_L3);
  assign accept    = (state_q == S_IDLE) && in_valid;
  assign w_rd      = in_layer && (k_q <= fan);
  assign mac_en    = in_layer && (k_q != '0) && (k_q <= fan);
  assign wb        = in_layer && (k_q == fan + ONE);
  assign fin       = (state_q == S_L3) && (k_q == fan + AW'(2));
  assign last_grp  = (grp_q == ngrp - ONE);
  assign idx       = k_q - ONE;
  assign addr      = AW'(bank_q) * AW'(BANK_SIZE) + base
                   + ((k_q < fan) ? grp_q * fan + k_q : ngrp * fan + grp_q);
  assign w_addr    = w_rd ? addr : '0;
  assign in_ready  = (state_q == S_IDLE) && rst_n;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_OUT);

  always_comb begin
    act = '0;
    case (state_q)
      S_L1:    if (idx < AW'(IN_DIM)) act = x_q[idx[IW1-1:0]];
      S_L2:    if (idx < AW'(H1_DIM)) act = h1_q[idx[IW2-1:0]];
      S_L3:    if (idx < AW'(H2_DIM)) act = h2_q[idx[IW3-1:0]];
      default: act = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_L1;
      S_L1:    if (wb && last_grp) state_d = S_L2;
      S_L2:    if (wb && last_grp) state_d = S_L3;
      S_L3:    if (fin) state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0; grp_q <= '0; bank_q <= '0; x_q <= '0;
      h1_q <= '0; h2_q <= '0; h3_q <= '0; out_i <= '0; out_q <= '0;
    end else begin
      if (accept) begin
        x_q <= in_vector; bank_q <= bank_sel; k_q <= '0; grp_q <= '0;
      end else if (fin) begin
        k_q <= '0; grp_q <= '0; out_i <= h3_q[0]; out_q <= h3_q[1];
      end else if (wb && !((state_q == S_L3) && last_grp)) begin
        k_q   <= '0;
        grp_q <= last_grp ? '0 : grp_q + ONE;
      end else if (in_layer) begin
        k_q <= k_q + ONE;
      end
      // Lanes mapping past the layer width are dropped here.
      if (wb) begin
        for (int j = 0; j < NUM_MACS; j++) begin
          if (state_q == S_L1 && nidx[j] < AW'(H1_DIM)) h1_q[nidx[j][IW2-1:0]] <= res[j];
          if (state_q == S_L2 && nidx[j] < AW'(H2_DIM)) h2_q[nidx[j][IW3-1:0]] <= res[j];
          if (state_q == S_L3 && nidx[j] < AW'(OUT_DIM)) h3_q[nidx[j][OW-1:0]] <= res[j];
        end
      end
    end
  end

  for (genvar j = 0; j < NUM_MACS; j++) begin : g_lane
    assign nidx[j] = grp_q * AW'(NUM_MACS) + AW'(j);
    tdnn_mac_lane #(.ACC_WIDTH(ACC_WIDTH), .ALPHA_SHIFT(ALPHA_SHIFT)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wb),
      .mac_en  (mac_en),
      .l1_mode (state_q == S_L1),
      .l3_mode (state_q == S_L3),
      .act     (act),
      .wd      (w_data[16*j +: 16]),
      .res     (res[j])
    );
  end

endmodule

// File: tb/tb_tdnn_mac_engine.sv
// Directed bench: banked weight memory model, table of end-to-end cases plus hold/reset sequences.
module tb_tdnn_mac_engine;
  localparam int IN_DIM = 22;
  localparam int NM     = 4;
  localparam int NB     = 4;
  localparam int BS     = 333;
  localparam int L2B    = 184;
  localparam int L3B    = 316;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [16*IN_DIM-1:0] in_vector;
  logic                 in_valid, in_ready, w_rd, out_valid, out_ready, busy;
  logic [1:0]           bank_sel;
  logic [15:0]          w_addr, out_i, out_q;
  logic [16*NM-1:0]     w_data;
  logic [16*NM-1:0]     mem [0:NB*BS-1];
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          sc;
    logic [1:0]  bank;
    bit          toggle;
    logic [15:0] exp_i;
    logic [15:0] exp_q;
  } vec_t;
  vec_t tbl [4];

  tdnn_mac_engine dut (
    .clk(clk), .rst_n(rst_n), .in_vector(in_vector), .in_valid(in_valid),
    .in_ready(in_ready), .bank_sel(bank_sel), .w_addr(w_addr), .w_rd(w_rd),
    .w_data(w_data), .out_i(out_i), .out_q(out_q), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) w_data <= (w_rd && int'(w_addr) < NB*BS) ? mem[w_addr] : '0;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_word(input int bank, input int addr, input int lane, input logic [15:0] v);
    mem[bank*BS + addr][16*lane +: 16] = v;
  endtask

  task automatic setup(input int sc);
    for (int a = 0; a < NB*BS; a++) mem[a] = '0;
    in_vector = '0;
    case (sc)
      0: for (int i = 0; i < IN_DIM; i++) in_vector[16*i +: 16] = 16'(i*1237 + 'h1111);
      1: begin
        in_vector[15:0] = 16'h7FFF;
        set_word(1, L3B+16, 0, 16'h0300);
        set_word(1, L3B+16, 1, 16'hFD00);
      end
      2: begin
        in_vector[15:0]  = 16'h4000;
        in_vector[31:16] = 16'h4000;
        set_word(3, 0,      1, 16'h4000);
        set_word(3, 1,      2, 16'hC000);
        set_word(3, 176,    0, 16'hFF00);
        set_word(3, 177,    1, 16'h0180);
        set_word(3, L2B,    0, 16'h7FFF);
        set_word(3, L3B,    0, 16'h7FFF);
      end
      default: begin
        for (int i = 0; i < IN_DIM; i++) in_vector[16*i +: 16] = 16'($urandom);
        for (int b = 0; b < NB; b++) set_word(b, L3B+16, 0, (b == 2) ? 16'h0080 : 16'h0100);
        set_word(2, L3B+16, 1, 16'hFF80);
        set_word(2, L3B+16, 2, 16'h0300);
      end
    endcase
  endtask

  // Latency counts cycles from the accept cycle to the first cycle showing out_valid.
  task automatic run_sample(input logic [1:0] bank, input bit toggle,
                            output int lat, output int amin, output int amax);
    @(negedge clk);
    bank_sel = bank;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1; amin = 32'h7FFF_FFFF; amax = -1;
    while (!out_valid && lat < 1000) begin
      if (w_rd) begin
        if (int'(w_addr) < amin) amin = int'(w_addr);
        if (int'(w_addr) > amax) amax = int'(w_addr);
      end
      if (toggle) begin
        bank_sel = 2'(lat / 40);
        in_valid = (lat >= 100 && lat < 110);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, in_ready, 1);
    chk({tag, "_out_valid_after"}, out_valid, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int lat, amin, amax;
    bit stable, seen;
    tbl[0] = '{0, 2'd0, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{1, 2'd1, 1'b0, 16'h7F80, 16'h8000};
    tbl[2] = '{2, 2'd3, 1'b0, 16'hF800, 16'h0000};
    tbl[3] = '{3, 2'd2, 1'b1, 16'h4000, 16'hC000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bank_sel = '0; in_vector = '0;
    for (int a = 0; a < NB*BS; a++) mem[a] = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_rd", w_rd, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_out_i", out_i, 0);
    chk("rst_out_q", out_q, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    for (int t = 0; t < 4; t++) begin
      setup(tbl[t].sc);
      run_sample(tbl[t].bank, tbl[t].toggle, lat, amin, amax);
      chk($sformatf("t%0d_latency", t), lat, 348);
      chk($sformatf("t%0d_out_valid", t), out_valid, 1);
      chk($sformatf("t%0d_out_i", t), out_i, tbl[t].exp_i);
      chk($sformatf("t%0d_out_q", t), out_q, tbl[t].exp_q);
      chk($sformatf("t%0d_addr_min", t), amin, int'(tbl[t].bank) * BS);
      chk($sformatf("t%0d_addr_max", t), amax, int'(tbl[t].bank) * BS + BS - 1);
      if (tbl[t].sc == 2) begin
        chk("h1_0_leaky_neg", dut.h1_q[0], 16'hFFC0);
        chk("h1_1_pos", dut.h1_q[1], 16'h0040);
        chk("h1_2_mac_neg", dut.h1_q[2], 16'hFFF0);
        chk("h1_5_bias_grp1", dut.h1_q[5], 16'h0180);
        chk("h2_0_chain", dut.h2_q[0], 16'hFFF0);
      end
      if (tbl[t].sc == 1) begin
        stable = 1'b1;
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (!out_valid || in_ready || out_i !== tbl[t].exp_i || out_q !== tbl[t].exp_q)
            stable = 1'b0;
        end
        chk("hold_stable", stable, 1);
      end
      release_out($sformatf("t%0d", t));
    end

    // Reset mid-L2, then the same sample must run cleanly from scratch.
    setup(2);
    @(negedge clk);
    bank_sel = 2'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (250) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_w_rd", w_rd, 0);
    chk("mrst_w_addr", w_addr, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_h1_cleared", dut.h1_q[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_stale_out_valid", seen, 0);
    run_sample(2'd3, 1'b0, lat, amin, amax);
    chk("post_rst_latency", lat, 348);
    chk("post_rst_out_i", out_i, 16'hF800);
    chk("post_rst_out_q", out_q, 16'h0000);
    release_out("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
